tdc_thermo_decoder: RTL and testbench

Pipelined thermometer-to-binary decoder and trace averager that sits directly downstream of the carry-chain TDC.
- Takes the chain's N-bit registered tap vector, removes bubbles, and converts it to a delay code (count of ones).
- Subtracts a calibration offset from the code.
- Averages 2^LOG2_AVG consecutive codes into one trace point for the RPA capture path, with a valid/ready output.
- Drives the chain's sample enable and clear.

---
 rtl/tdc_thermo_decoder_pkg.sv | 8 +
 rtl/tdc_popcount.sv | 48 ++++
 rtl/tdc_thermo_decoder.sv | 101 ++++++++++
 tb/tb_tdc_thermo_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tdc_thermo_decoder_pkg.sv
// tdc_pkg: shared constants, code-width helper and FSM state type for the TDC decoder.
package tdc_pkg;
  localparam int N_DEFAULT = 128;
  function automatic int code_width(input int n);
    return $clog2(n + 1);
  endfunction
  typedef enum logic {IDLE, RUN} tdc_dec_state_t;
endpackage

// File: rtl/tdc_popcount.sv
// tdc_popcount: two-register-stage ones counter (group partials, then final sum) with valid passthrough.
module tdc_popcount import tdc_pkg::*; #(
  parameter int N     = N_DEFAULT,
  parameter int GROUP = 16
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [N-1:0]             bits_i,
  input  logic                     valid_i,
  output logic [code_width(N)-1:0] count_o,
  output logic                     valid_o
);
  localparam int CW = code_width(N);
  localparam int NG = (N + GROUP - 1) / GROUP;
  localparam int PW = code_width(GROUP);
  logic [NG*GROUP-1:0] bits;
  logic [PW-1:0]       part_d [NG];
  logic [PW-1:0]       part_q [NG];
  logic [CW-1:0]       sum_d, count_q;
  logic                v2_q, v3_q;
  // Zero-pad the last group when N is not a multiple of GROUP.
  assign bits = (NG*GROUP)'(bits_i);
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      part_d[g] = '0;
      for (int b = 0; b < GROUP; b++) part_d[g] = part_d[g] + PW'(bits[g*GROUP+b]);
    end
  end
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NG; g++) sum_d = sum_d + CW'(part_q[g]);
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      part_q  <= '{default: '0};
      v2_q    <= 1'b0;
      count_q <= '0;
      v3_q    <= 1'b0;
    end else begin
      part_q  <= part_d;
      v2_q    <= valid_i;
      count_q <= sum_d;
      v3_q    <= v2_q;
    end
  end
  assign count_o = count_q;
  assign valid_o = v3_q;
endmodule

// File: rtl/tdc_thermo_decoder.sv
// tdc_thermo_decoder: bubble-filtered thermometer-to-code pipeline with offset
// correction and a 2^LOG2_AVG trace averager behind a valid/ready register.
module tdc_thermo_decoder import tdc_pkg::*; #(
  parameter int N        = N_DEFAULT,
  parameter int LOG2_AVG = 4
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [N-1:0]             tap_in,
  input  logic                     sample_en,
  input  logic                     start,
  input  logic                     cont,
  input  logic [code_width(N)-1:0] offset,
  output logic                     chain_ena,
  output logic                     chain_clr,
  output logic [code_width(N)-1:0] code,
  output logic                     code_valid,
  output logic [code_width(N)-1:0] avg_data,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic                     busy,
  output logic                     overrun
);
  localparam int CW = code_width(N);
  localparam int AW = CW + LOG2_AVG;
  localparam logic [LOG2_AVG:0] LAST = (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);
  logic [N-1:0]      t_q, f_q, t_lo, t_hi, f_d;
  logic              v0_q, v1_q, v3;
  logic [CW-1:0]     raw, code_d, code_q, off_q, avg_data_q;
  logic              code_valid_q, avg_valid_q, overrun_q, chain_clr_q;
  logic [AW-1:0]     acc_q, sum;
  logic [LOG2_AVG:0] cnt_q;
  logic              complete, load;
  tdc_dec_state_t    state_q, state_d;
  // Neighbours with the chain boundaries tied off: below bit 0 is 1, above bit N-1 is 0.
  assign t_lo = {t_q[N-2:0], 1'b1};
  assign t_hi = {1'b0, t_q[N-1:1]};
  assign f_d  = (t_lo & t_q) | (t_lo & t_hi) | (t_q & t_hi);
  tdc_popcount #(.N(N), .GROUP(16)) u_pop (
    .clk(clk), .clrn(clrn), .bits_i(f_q), .valid_i(v1_q), .count_o(raw), .valid_o(v3)
  );
  assign code_d = (raw > off_q) ? raw - off_q : '0;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      t_q          <= '0;
      v0_q         <= 1'b0;
      f_q          <= '0;
      v1_q         <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      chain_clr_q  <= 1'b0;
    end else begin
      t_q          <= tap_in;
      v0_q         <= sample_en;
      f_q          <= f_d;
      v1_q         <= v0_q;
      code_valid_q <= v3;
      if (v3) code_q <= code_d;
      chain_clr_q  <= start;
    end
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb state_d = start ? RUN : complete ? (cont ? RUN : IDLE) : state_q;
  always_comb busy = (state_q == RUN);
  // A start in the same cycle as the final code restarts the window instead of completing it.
  assign complete = busy && code_valid_q && !start && (cnt_q == LAST);
  assign sum      = acc_q + AW'(code_q);
  assign load     = complete && (!avg_valid_q || avg_ready);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (start) begin
        acc_q <= '0;
        cnt_q <= '0;
        off_q <= offset;
      end else if (busy && code_valid_q) begin
        acc_q <= complete ? '0 : sum;
        cnt_q <= complete ? '0 : cnt_q + 1'b1;
      end
      if (load) avg_data_q <= sum[AW-1:LOG2_AVG];
      avg_valid_q <= load || (avg_valid_q && !avg_ready);
      overrun_q   <= !start && (overrun_q || (complete && avg_valid_q && !avg_ready));
    end
  end
  assign chain_ena  = sample_en;
  assign chain_clr  = chain_clr_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign avg_data   = avg_data_q;
  assign avg_valid  = avg_valid_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// tb_tdc_thermo_decoder: vector table for the per-sample code path plus directed
// sequences for averaging, overrun and mid-window reset.
module tb_tdc_thermo_decoder;
  logic         clk = 1'b0, clrn = 1'b1;
  logic [127:0] tap_in = '0;
  logic         sample_en = 1'b0, start = 1'b0, cont = 1'b0, avg_ready = 1'b0;
  logic [7:0]   offset = '0;
  logic         chain_ena, chain_clr, code_valid, avg_valid, busy, overrun;
  logic [7:0]   code, avg_data;
  int           errors = 0, checks = 0;

  typedef struct {
    logic [127:0] tap;
    logic [7:0]   off;
    logic [7:0]   exp;
  } vec_t;
  vec_t vecs [10];

  tdc_thermo_decoder #(.N(128), .LOG2_AVG(4)) dut (
    .clk(clk), .clrn(clrn), .tap_in(tap_in), .sample_en(sample_en), .start(start),
    .cont(cont), .offset(offset), .chain_ena(chain_ena), .chain_clr(chain_clr),
    .code(code), .code_valid(code_valid), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ones(input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] o);
    offset = o;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic burst(input logic [127:0] a, input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tap_in    = (i % 2 == 0) ? a : b;
      sample_en = 1'b1;
      @(negedge clk);
    end
    sample_en = 1'b0;
  endtask

  initial begin
    logic [127:0] bt;
    int           waited;
    vecs[0] = '{ones(40), 8'd0, 8'd40};
    bt = ones(40); bt[37] = 1'b0; bt[60] = 1'b1;
    vecs[1] = '{bt, 8'd0, 8'd40};
    vecs[2] = '{ones(40), 8'd50, 8'd0};
    vecs[3] = '{ones(128), 8'd0, 8'd128};
    vecs[4] = '{128'd0, 8'd0, 8'd0};
    vecs[5] = '{ones(40), 8'd10, 8'd30};
    vecs[6] = '{ones(40), 8'd40, 8'd0};
    vecs[7] = '{ones(40), 8'd39, 8'd1};
    bt = ones(40); bt[0] = 1'b0;
    vecs[8] = '{bt, 8'd0, 8'd40};
    vecs[9] = '{ones(128), 8'd127, 8'd1};

    #2 clrn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_code", code, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_avg", {avg_valid, avg_data}, 0);
    chk("rst_flags", {busy, overrun, chain_clr}, 0);
    clrn = 1'b1;
    @(negedge clk);

    sample_en = 1'b1;
    #1 chk("chain_ena_hi", chain_ena, 1);
    sample_en = 1'b0;
    #1 chk("chain_ena_lo", chain_ena, 0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      pulse_start(vecs[i].off);
      chk($sformatf("chain_clr[%0d]", i), chain_clr, 1);
      burst(vecs[i].tap, vecs[i].tap, 1);
      chk($sformatf("chain_clr_off[%0d]", i), chain_clr, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("early_valid[%0d]", i), code_valid, 0);
      @(negedge clk);
      chk($sformatf("code_valid[%0d]", i), code_valid, 1);
      chk($sformatf("code[%0d]", i), code, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("valid_pulse[%0d]", i), code_valid, 0);
    end

    // One averaging window of alternating 10/11 codes, single-shot.
    cont = 1'b0;
    pulse_start(8'd0);
    chk("busy_run", busy, 1);
    burst(ones(10), ones(11), 16);
    repeat (4) @(negedge clk);
    chk("avg_not_yet", avg_valid, 0);
    chk("busy_before_end", busy, 1);
    @(negedge clk);
    chk("avg_valid", avg_valid, 1);
    chk("avg_data", avg_data, 10);
    chk("busy_idle", busy, 0);
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    chk("avg_handshake", avg_valid, 0);

    // Continuous mode with a stalled consumer: second result must be dropped.
    cont = 1'b1;
    pulse_start(8'd0);
    burst(ones(40), ones(40), 16);
    burst(128'd0, 128'd0, 16);
    repeat (6) @(negedge clk);
    chk("ovr_valid", avg_valid, 1);
    chk("ovr_held", avg_data, 40);
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 1);
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    chk("ovr_handshake", avg_valid, 0);
    chk("ovr_sticky", overrun, 1);
    cont = 1'b0;
    pulse_start(8'd0);
    chk("ovr_clear", overrun, 0);

    // Reset while a window is partly filled and codes are in flight.
    burst(ones(40), ones(40), 7);
    clrn = 1'b0;
    #1;
    chk("mid_rst_code", {code_valid, code}, 0);
    chk("mid_rst_avg", {avg_valid, avg_data}, 0);
    chk("mid_rst_flags", {busy, overrun, chain_clr}, 0);
    @(negedge clk);
    clrn = 1'b1;
    waited = 0;
    repeat (6) begin
      @(negedge clk);
      if (code_valid) waited++;
    end
    chk("flushed", waited, 0);
    pulse_start(8'd0);
    burst(ones(20), ones(20), 16);
    waited = 0;
    while (!avg_valid && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk("post_rst_avg_valid", avg_valid, 1);
    chk("post_rst_avg_data", avg_data, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
